// File: rtl/frame_load_ctrl_if.sv
// frame_load_ctrl_if: UART byte input and BRAM write-port A bundle for frame_load_ctrl
interface frame_load_ctrl_if #(parameter int ADDR_W = 18);
  logic [7:0] rx_data;
  logic rx_ready;
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [23:0] wdata;
  logic busy;
  logic frame_done;
  logic error;
  modport master(output rx_data, rx_ready, input we, waddr, wdata, busy, frame_done, error);
  modport slave(input rx_data, rx_ready, output we, waddr, wdata, busy, frame_done, error);
endinterface

// File: rtl/frame_load_ctrl.sv
// frame_load_ctrl: parses 'L'/'F' UART commands into frame-buffer writes on BRAM port A
module frame_load_ctrl #(
  parameter int PIXEL_COUNT = 172800,
  parameter int ADDR_W = 18,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic clk,
  input logic reset,
  frame_load_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_COUNT - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, FILL_COLOR, FILL_RUN} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] pix, waddr;
  logic [TW-1:0] tcnt;
  logic [1:0] bidx;
  logic [7:0] r, g;
  logic [23:0] wdata;
  logic we, done, error, rx, third, last, tmo;
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = !rx ? IDLE : bus.rx_data == 8'h4C ? LOAD : bus.rx_data == 8'h46 ? FILL_COLOR : IDLE;
      LOAD: next = (last || tmo) ? IDLE : LOAD;
      FILL_COLOR: next = tmo ? IDLE : (rx && third) ? FILL_RUN : FILL_COLOR;
      FILL_RUN: next = last ? IDLE : FILL_RUN;
      default: next = IDLE;
    endcase
  end
  // last marks the cycle carrying the write to the final pixel; completion follows it
  always_comb begin
    rx = bus.rx_ready;
    third = bidx == 2'd2;
    last = we && waddr == LAST_ADDR;
    tmo = !rx && tcnt == T_MAX && (state == LOAD || state == FILL_COLOR);
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pix <= '0;
      waddr <= '0;
      wdata <= '0;
      tcnt <= '0;
      bidx <= '0;
      r <= '0;
      g <= '0;
      we <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      we <= 1'b0;
      done <= last && (state == LOAD || state == FILL_RUN);
      tcnt <= (rx || state == IDLE || state == FILL_RUN) ? '0 : tcnt + TW'(1);
      if (tmo) error <= 1'b1;
      case (state)
        IDLE: if (next != IDLE) begin
          pix <= '0;
          bidx <= '0;
          error <= 1'b0;
        end
        // the third colour byte of a fill issues the address-0 write as it enters FILL_RUN
        LOAD, FILL_COLOR: if (rx && !last) begin
          bidx <= third ? 2'd0 : bidx + 2'd1;
          if (bidx == 2'd0) r <= bus.rx_data;
          if (bidx == 2'd1) g <= bus.rx_data;
          if (third) begin
            we <= 1'b1;
            waddr <= state == LOAD ? pix : '0;
            wdata <= {r, g, bus.rx_data};
            pix <= pix + ADDR_W'(1);
          end
        end
        FILL_RUN: if (!last) begin
          we <= 1'b1;
          waddr <= waddr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
  assign bus.we = we;
  assign bus.waddr = waddr;
  assign bus.wdata = wdata;
  assign bus.frame_done = done;
  assign bus.error = error;
endmodule

// File: tb/tb_frame_load_ctrl.sv
// tb_frame_load_ctrl: table-driven per-cycle vectors plus a timeout race sequence
module tb_frame_load_ctrl;
  localparam int PC = 4;
  localparam int AW = 2;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  frame_load_ctrl_if #(.ADDR_W(AW)) bus();
  frame_load_ctrl #(.PIXEL_COUNT(PC), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  typedef struct {
    logic rst;
    logic rx;
    logic [7:0] d;
    logic we;
    logic [AW-1:0] a;
    logic [23:0] wd;
    logic busy;
    logic done;
    logic err;
  } vec_t;
  vec_t tbl[$];
  int checks = 0;
  int fails = 0;
  function automatic vec_t mk(int rst, int rx, int d, int we, int a, int wd, int busy, int done, int err);
    vec_t v;
    v.rst = 1'(rst);
    v.rx = 1'(rx);
    v.d = 8'(d);
    v.we = 1'(we);
    v.a = AW'(a);
    v.wd = 24'(wd);
    v.busy = 1'(busy);
    v.done = 1'(done);
    v.err = 1'(err);
    return v;
  endfunction
  function automatic void p(int rst, int rx, int d, int we, int a, int wd, int busy, int done, int err);
    tbl.push_back(mk(rst, rx, d, we, a, wd, busy, done, err));
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    reset = v.rst;
    bus.rx_ready = v.rx;
    bus.rx_data = v.d;
    @(posedge clk);
    #1;
    chk({tag, " we"}, int'(bus.we), int'(v.we));
    chk({tag, " waddr"}, int'(bus.waddr), int'(v.a));
    chk({tag, " wdata"}, int'(bus.wdata), int'(v.wd));
    chk({tag, " busy"}, int'(bus.busy), int'(v.busy));
    chk({tag, " frame_done"}, int'(bus.frame_done), int'(v.done));
    chk({tag, " error"}, int'(bus.error), int'(v.err));
  endtask
  initial begin
    bit seen;
    bus.rx_ready = 1'b0;
    bus.rx_data = 8'h00;
    p(1, 0, 0, 0, 0, 0, 0, 0, 0);
    p(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // full frame load
    p(0, 1, 'h4C, 0, 0, 0, 1, 0, 0);
    p(0, 1, 'h11, 0, 0, 0, 1, 0, 0);
    p(0, 1, 'h22, 0, 0, 0, 1, 0, 0);
    p(0, 1, 'h33, 1, 0, 'h112233, 1, 0, 0);
    p(0, 0, 0, 0, 0, 'h112233, 1, 0, 0);
    p(0, 1, 'h44, 0, 0, 'h112233, 1, 0, 0);
    p(0, 1, 'h55, 0, 0, 'h112233, 1, 0, 0);
    p(0, 1, 'h66, 1, 1, 'h445566, 1, 0, 0);
    p(0, 1, 'h77, 0, 1, 'h445566, 1, 0, 0);
    p(0, 1, 'h88, 0, 1, 'h445566, 1, 0, 0);
    p(0, 1, 'h99, 1, 2, 'h778899, 1, 0, 0);
    p(0, 1, 'hAA, 0, 2, 'h778899, 1, 0, 0);
    p(0, 1, 'hBB, 0, 2, 'h778899, 1, 0, 0);
    p(0, 1, 'hCC, 1, 3, 'hAABBCC, 1, 0, 0);
    p(0, 0, 0, 0, 3, 'hAABBCC, 0, 1, 0);
    p(0, 0, 0, 0, 3, 'hAABBCC, 0, 0, 0);
    // constant fill with a dropped byte during the run
    p(0, 1, 'h46, 0, 3, 'hAABBCC, 1, 0, 0);
    p(0, 1, 'h0F, 0, 3, 'hAABBCC, 1, 0, 0);
    p(0, 1, 'hF0, 0, 3, 'hAABBCC, 1, 0, 0);
    p(0, 1, 'h0F, 1, 0, 'h0FF00F, 1, 0, 0);
    p(0, 1, 'h55, 1, 1, 'h0FF00F, 1, 0, 0);
    p(0, 0, 0, 1, 2, 'h0FF00F, 1, 0, 0);
    p(0, 0, 0, 1, 3, 'h0FF00F, 1, 0, 0);
    p(0, 0, 0, 0, 3, 'h0FF00F, 0, 1, 0);
    p(0, 0, 0, 0, 3, 'h0FF00F, 0, 0, 0);
    // unknown bytes in IDLE
    p(0, 1, 'h00, 0, 3, 'h0FF00F, 0, 0, 0);
    p(0, 1, 'hFF, 0, 3, 'h0FF00F, 0, 0, 0);
    // timeout after a partial pixel
    p(0, 1, 'h4C, 0, 3, 'h0FF00F, 1, 0, 0);
    p(0, 1, 'h01, 0, 3, 'h0FF00F, 1, 0, 0);
    p(0, 1, 'h02, 0, 3, 'h0FF00F, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) p(0, 0, 0, 0, 3, 'h0FF00F, 1, 0, 0);
    p(0, 0, 0, 0, 3, 'h0FF00F, 0, 0, 1);
    p(0, 1, 'h00, 0, 3, 'h0FF00F, 0, 0, 1);
    p(0, 1, 'h46, 0, 3, 'h0FF00F, 1, 0, 0);
    p(0, 1, 'h01, 0, 3, 'h0FF00F, 1, 0, 0);
    p(0, 1, 'h02, 0, 3, 'h0FF00F, 1, 0, 0);
    p(0, 1, 'h03, 1, 0, 'h010203, 1, 0, 0);
    p(0, 0, 0, 1, 1, 'h010203, 1, 0, 0);
    p(0, 0, 0, 1, 2, 'h010203, 1, 0, 0);
    p(0, 0, 0, 1, 3, 'h010203, 1, 0, 0);
    p(0, 0, 0, 0, 3, 'h010203, 0, 1, 0);
    // reset in the middle of a load, then restart at address 0
    p(0, 1, 'h4C, 0, 3, 'h010203, 1, 0, 0);
    p(0, 1, 'hA1, 0, 3, 'h010203, 1, 0, 0);
    p(0, 1, 'hA2, 0, 3, 'h010203, 1, 0, 0);
    p(0, 1, 'hA3, 1, 0, 'hA1A2A3, 1, 0, 0);
    p(0, 1, 'h04, 0, 0, 'hA1A2A3, 1, 0, 0);
    p(1, 0, 0, 0, 0, 0, 0, 0, 0);
    p(0, 1, 'h4C, 0, 0, 0, 1, 0, 0);
    p(0, 1, 'h11, 0, 0, 0, 1, 0, 0);
    p(0, 1, 'h22, 0, 0, 0, 1, 0, 0);
    p(0, 1, 'h33, 1, 0, 'h112233, 1, 0, 0);
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));
    // race: a byte in the cycle the timeout would expire is accepted
    apply(mk(0, 1, 'h44, 0, 0, 'h112233, 1, 0, 0), "race_r");
    for (int i = 0; i < TO - 1; i++) apply(mk(0, 0, 0, 0, 0, 'h112233, 1, 0, 0), $sformatf("race_quiet%0d", i));
    apply(mk(0, 1, 'h55, 0, 0, 'h112233, 1, 0, 0), "race_g");
    apply(mk(0, 0, 0, 0, 0, 'h112233, 1, 0, 0), "race_after");
    apply(mk(0, 1, 'h66, 1, 1, 'h445566, 1, 0, 0), "race_b");
    apply(mk(0, 1, 'h77, 0, 1, 'h445566, 1, 0, 0), "race_p2r");
    apply(mk(0, 1, 'h88, 0, 1, 'h445566, 1, 0, 0), "race_p2g");
    apply(mk(0, 1, 'h99, 1, 2, 'h778899, 1, 0, 0), "race_p2b");
    apply(mk(0, 1, 'hAA, 0, 2, 'h778899, 1, 0, 0), "race_p3r");
    apply(mk(0, 1, 'hBB, 0, 2, 'h778899, 1, 0, 0), "race_p3g");
    apply(mk(0, 1, 'hCC, 1, 3, 'hAABBCC, 1, 0, 0), "race_p3b");
    @(negedge clk);
    bus.rx_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done) seen = 1'b1;
    end
    chk("race_frame_done", int'(seen), 1);
    chk("race_error", int'(bus.error), 0);
    chk("race_busy", int'(bus.busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
